// File: rtl/gf_poly_eval.sv
// Horner-rule evaluator: y = z(x) over GF(2^8), one coefficient per clock through a single shared GF multiplier.
// Latency: done pulses large_array+1 edges after the start edge (5 with defaults); y holds until the next accepted start.
// Backpressure: none; start is taken only while idle and ignored while busy, so callers wait for !busy or done.
module gf_poly_eval #(
  parameter int m                = 255,
  parameter int SIZE             = $clog2(m),
  parameter int n                = 2,
  parameter int large_array      = 2*n,
  parameter int large_array_size = (large_array+1)*SIZE,
  parameter logic [SIZE:0] PRIM  = 9'h11D
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [large_array_size-1:0] flat_z,
  input  logic [SIZE-1:0]             x,
  output logic                        busy,
  output logic                        done,
  output logic [SIZE-1:0]             y
);

  localparam int IDX_W = $clog2(large_array+1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                      state, state_nxt;
  logic [large_array_size-1:0] flat_z_l;
  logic [SIZE-1:0]             x_l;
  logic [SIZE-1:0]             acc;
  logic [SIZE-1:0]             acc_nxt;
  logic [SIZE-1:0]             coef;
  logic [IDX_W-1:0]            idx;
  logic                        accept;
  logic                        last;

  // Shift-and-add multiply; each doubling folds bit SIZE back in via the low bits of PRIM.
  function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic [SIZE-1:0] p;
    logic [SIZE-1:0] s;
    p = '0;
    s = a;
    for (int i = 0; i < SIZE; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[SIZE-2:0], 1'b0} ^ (s[SIZE-1] ? PRIM[SIZE-1:0] : '0);
    end
    return p;
  endfunction

  assign coef    = flat_z_l[int'(idx)*SIZE +: SIZE];
  assign acc_nxt = gf_mul(acc, x_l) ^ coef;
  assign busy    = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx == '0) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured on acceptance so the caller may change flat_z/x mid-evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flat_z_l <= '0;
      x_l      <= '0;
      acc      <= '0;
      idx      <= '0;
      y        <= '0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        flat_z_l <= flat_z;
        x_l      <= x;
        acc      <= '0;
        idx      <= IDX_W'(large_array);
      end else if (state == RUN) begin
        acc <= acc_nxt;
        if (last) y   <= acc_nxt;
        else      idx <= idx - 1'b1;
      end
    end
  end

endmodule
